// File: rtl/ap_mult_share_arb.sv
// -----------------------------------------------------------------------------
// ap_mult_share_arb
//
// Round-robin front end that shares one external pipelined multiplier among
// NREQ requesters. Each requester may have at most one operation outstanding;
// a per-requester pend flag enforces that. Granted operands are registered onto
// the multiplier inputs. A tag pipeline tracks which requester owns each
// product and steers it into that requester's result slot, which then follows
// a valid/ready handshake. The product is passed through untouched.
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   req_vld   in   [NREQ]       request valid per requester
//   req_rdy   out  [NREQ]       request accepted (one-hot or zero, combinational)
//   req_a     in   [NREQ*W]     operand A, requester i at [i*W +: W]
//   req_b     in   [NREQ*W]     operand B, same packing
//   mul_vld   out               operands valid to multiplier (registered)
//   mul_a     out  [W]          operand A to multiplier (registered)
//   mul_b     out  [W]          operand B to multiplier (registered)
//   mul_p     in   [2W]         product, valid LAT cycles after mul_vld
//   rsp_vld   out  [NREQ]       result valid per requester
//   rsp_p     out  [NREQ*2W]    result, requester i at [i*2W +: 2W]
//   rsp_rdy   in   [NREQ]       result accepted per requester
//   busy      out               OR of all pend flags (registered)
//   grant_id  out  [clog2 NREQ] last granted requester (registered)
// -----------------------------------------------------------------------------
module ap_mult_share_arb #(
    parameter int NREQ = 4,
    parameter int W    = 12,
    parameter int LAT  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_vld,
    output logic [NREQ-1:0]           req_rdy,
    input  logic [NREQ*W-1:0]         req_a,
    input  logic [NREQ*W-1:0]         req_b,
    output logic                      mul_vld,
    output logic [W-1:0]              mul_a,
    output logic [W-1:0]              mul_b,
    input  logic [2*W-1:0]            mul_p,
    output logic [NREQ-1:0]           rsp_vld,
    output logic [NREQ*2*W-1:0]       rsp_p,
    input  logic [NREQ-1:0]           rsp_rdy,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id
);

    localparam int IDW = $clog2(NREQ);
    // Wide enough to hold grant_id + NREQ before the wrap subtraction.
    localparam int SW  = IDW + 2;
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    // ------------------------------------------------------------------
    // Per-requester state gathered into vectors
    // ------------------------------------------------------------------
    logic [NREQ-1:0] pend_q;
    logic [NREQ-1:0] pend_d;
    logic [NREQ-1:0] eligible;

    // ------------------------------------------------------------------
    // Issue stage registers
    // ------------------------------------------------------------------
    logic           mul_vld_q;
    logic [W-1:0]   mul_a_q;
    logic [W-1:0]   mul_b_q;
    logic [IDW-1:0] grant_id_q;
    logic           busy_q;

    // ------------------------------------------------------------------
    // Tag pipeline: stage 0 follows mul_vld, so the last stage lines up
    // with mul_p exactly LAT cycles after mul_vld.
    // ------------------------------------------------------------------
    logic [LAT-1:0]          tag_vld_q;
    logic [LAT-1:0][IDW-1:0] tag_id_q;
    logic                    tag_out_vld;
    logic [IDW-1:0]          tag_out_id;

    // ------------------------------------------------------------------
    // Round-robin arbitration
    // ------------------------------------------------------------------
    logic [SW-1:0]   cand;
    logic            gnt_vld;
    logic [IDW-1:0]  gnt_idx;
    logic [NREQ-1:0] gnt_onehot;
    logic            issue;

    assign eligible = req_vld & ~pend_q;

    always_comb begin
        cand       = '0;
        gnt_vld    = 1'b0;
        gnt_idx    = '0;
        gnt_onehot = '0;
        // Search starts just after the last grant and wraps, so the most
        // recently served requester has the lowest priority.
        for (int k = 1; k <= NREQ; k++) begin
            cand = SW'(grant_id_q) + SW'(k);
            if (cand >= SW'(NREQ)) begin
                cand = cand - SW'(NREQ);
            end
            if (!gnt_vld && eligible[cand[IDW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[IDW-1:0];
            end
        end
        if (gnt_vld) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

    // The pointer and pend flags sit at their reset values while rst_n is
    // low; masking keeps req_rdy quiet during reset as well.
    assign req_rdy = rst_n ? gnt_onehot : '0;
    assign issue   = |req_rdy;

    // ------------------------------------------------------------------
    // Operand issue and arbitration pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_vld_q  <= 1'b0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            grant_id_q <= LAST_ID;
        end else begin
            mul_vld_q <= issue;
            if (issue) begin
                mul_a_q    <= req_a[gnt_idx*W +: W];
                mul_b_q    <= req_b[gnt_idx*W +: W];
                grant_id_q <= gnt_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline. grant_id_q holds the issued id whenever mul_vld_q is
    // high, so it doubles as the stage-0 tag id.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            tag_vld_q[0] <= mul_vld_q;
            tag_id_q[0]  <= grant_id_q;
            for (int j = 1; j < LAT; j++) begin
                tag_vld_q[j] <= tag_vld_q[j-1];
                tag_id_q[j]  <= tag_id_q[j-1];
            end
        end
    end

    assign tag_out_vld = tag_vld_q[LAT-1];
    assign tag_out_id  = tag_id_q[LAT-1];

    // ------------------------------------------------------------------
    // Per-requester pend flag and result slot
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
        logic           slot_pend_q;
        logic           slot_pend_d;
        logic           slot_vld_q;
        logic [2*W-1:0] slot_p_q;
        logic           req_hs;
        logic           rsp_hs;
        logic           cap;

        assign req_hs = req_rdy[gi];
        assign rsp_hs = slot_vld_q & rsp_rdy[gi];
        assign cap    = tag_out_vld & (tag_out_id == IDW'(gi));

        // A requester with a pending op is never granted, so req_hs and
        // rsp_hs cannot coincide; the ordering here is only for clarity.
        always_comb begin
            slot_pend_d = slot_pend_q;
            if (rsp_hs) begin
                slot_pend_d = 1'b0;
            end else if (req_hs) begin
                slot_pend_d = 1'b1;
            end
        end

        // pend guarantees the slot is empty whenever a capture targets it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_pend_q <= 1'b0;
                slot_vld_q  <= 1'b0;
                slot_p_q    <= '0;
            end else begin
                slot_pend_q <= slot_pend_d;
                if (cap) begin
                    slot_vld_q <= 1'b1;
                    slot_p_q   <= mul_p;
                end else if (rsp_hs) begin
                    slot_vld_q <= 1'b0;
                end
            end
        end

        assign pend_q[gi]               = slot_pend_q;
        assign pend_d[gi]               = slot_pend_d;
        assign rsp_vld[gi]              = slot_vld_q;
        assign rsp_p[gi*2*W +: 2*W]     = slot_p_q;
    end

    // busy follows the pend flags in the same cycle they change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= |pend_d;
        end
    end

    assign mul_vld  = mul_vld_q;
    assign mul_a    = mul_a_q;
    assign mul_b    = mul_b_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_ap_mult_share_arb.sv
// -----------------------------------------------------------------------------
// tb_ap_mult_share_arb
//
// Bench for ap_mult_share_arb (NREQ=4, W=12, LAT=2). An external multiplier
// model returns (a*b) ^ 1 LAT cycles after mul_vld, and junk otherwise. A
// monitor pushes the expected product into a scoreboard at each request
// handshake and checks latency and data at each response. Directed sections
// cover reset, single ops from a vector table, continuous round robin,
// backpressure, pointer wrap and reset in the middle of an operation.
// -----------------------------------------------------------------------------
module tb_ap_mult_share_arb;

    localparam int NREQ = 4;
    localparam int W    = 12;
    localparam int LAT  = 2;
    localparam int PW   = 2 * W;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_vld;
    logic [NREQ-1:0]       req_rdy;
    logic [NREQ*W-1:0]     req_a;
    logic [NREQ*W-1:0]     req_b;
    logic                  mul_vld;
    logic [W-1:0]          mul_a;
    logic [W-1:0]          mul_b;
    logic [PW-1:0]         mul_p;
    logic [NREQ-1:0]       rsp_vld;
    logic [NREQ*PW-1:0]    rsp_p;
    logic [NREQ-1:0]       rsp_rdy;
    logic                  busy;
    logic [1:0]            grant_id;

    ap_mult_share_arb #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_vld  (req_vld),
        .req_rdy  (req_rdy),
        .req_a    (req_a),
        .req_b    (req_b),
        .mul_vld  (mul_vld),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_p    (mul_p),
        .rsp_vld  (rsp_vld),
        .rsp_p    (rsp_p),
        .rsp_rdy  (rsp_rdy),
        .busy     (busy),
        .grant_id (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_rsp    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Approximate-multiplier stand-in: exact product with the LSB flipped.
    function automatic logic [PW-1:0] amul(input logic [W-1:0] a, input logic [W-1:0] b);
        return (PW'(a) * PW'(b)) ^ PW'(1);
    endfunction

    // ------------------------------------------------------------------
    // External multiplier model
    // ------------------------------------------------------------------
    logic [PW-1:0] mpipe [LAT];
    logic          fixed_en = 1'b0;
    logic [PW-1:0] fixed_p  = 24'hABCDEF;

    always @(posedge clk) begin
        if (mul_vld) mpipe[0] <= fixed_en ? fixed_p : amul(mul_a, mul_b);
        else         mpipe[0] <= PW'($urandom);
        for (int j = 1; j < LAT; j++) mpipe[j] <= mpipe[j-1];
    end
    assign mul_p = mpipe[LAT-1];

    // ------------------------------------------------------------------
    // Scoreboard and grant log
    // ------------------------------------------------------------------
    typedef struct { int id; logic [PW-1:0] p; int cyc; } sb_t;
    typedef struct { int id; int cyc; } gl_t;
    sb_t sb[$];
    gl_t glog[$];
    logic [NREQ-1:0] prev_vld = '0;

    function automatic int sb_find(input int id);
        for (int k = 0; k < sb.size(); k++) if (sb[k].id == id) return k;
        return -1;
    endfunction

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            sb.delete();
            prev_vld = '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_vld[i] && req_rdy[i]) begin
                    sb_t e;
                    gl_t g;
                    e.id = i; e.p = amul(req_a[i*W +: W], req_b[i*W +: W]); e.cyc = cyc;
                    g.id = i; g.cyc = cyc;
                    sb.push_back(e);
                    glog.push_back(g);
                    $display("issue req=%0d a=%h b=%h cyc=%0d", i, req_a[i*W +: W], req_b[i*W +: W], cyc);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                int idx;
                if (rsp_vld[i] && !prev_vld[i]) begin
                    idx = sb_find(i);
                    chk("rsp_has_pending_op", 64'(idx >= 0), 64'd1);
                    if (idx >= 0) chk("rsp_latency", 64'(cyc - sb[idx].cyc), 64'(LAT + 2));
                end
                if (rsp_vld[i] && rsp_rdy[i]) begin
                    idx = sb_find(i);
                    chk("rsp_hs_has_pending_op", 64'(idx >= 0), 64'd1);
                    if (idx >= 0) begin
                        chk("rsp_data", 64'(rsp_p[i*PW +: PW]), 64'(sb[idx].p));
                        sb.delete(idx);
                    end
                    n_rsp++;
                    $display("resp req=%0d p=%h cyc=%0d", i, rsp_p[i*PW +: PW], cyc);
                end
            end
            prev_vld = rsp_vld;
        end
    end

    // ------------------------------------------------------------------
    // Single-op vector table
    // ------------------------------------------------------------------
    typedef struct { int id; logic [W-1:0] a; logic [W-1:0] b; logic [PW-1:0] exp_p; } vec_t;
    vec_t vecs[6];

    task automatic single_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [PW-1:0] exp_p);
        @(posedge clk); #1;
        req_vld = NREQ'(1) << id;
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        @(negedge clk);
        chk("sop_req_rdy", 64'(req_rdy), 64'(NREQ'(1) << id));
        @(posedge clk); #1;
        req_vld = '0;
        @(negedge clk);
        chk("sop_mul_vld", 64'(mul_vld), 64'd1);
        chk("sop_mul_a", 64'(mul_a), 64'(a));
        chk("sop_mul_b", 64'(mul_b), 64'(b));
        chk("sop_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("sop_rsp_not_early", 64'(rsp_vld[id]), 64'd0);
        @(posedge clk); #1;
        rsp_rdy = NREQ'(1) << id;
        @(negedge clk);
        chk("sop_rsp_vld", 64'(rsp_vld[id]), 64'd1);
        chk("sop_rsp_p", 64'(rsp_p[id*PW +: PW]), 64'(exp_p));
        @(posedge clk); #1;
        rsp_rdy = '0;
        @(negedge clk);
        chk("sop_rsp_cleared", 64'(rsp_vld[id]), 64'd0);
        chk("sop_busy_cleared", 64'(busy), 64'd0);
    endtask

    task automatic drain_and_check(input string tag);
        rsp_rdy = '1;
        repeat (10) @(posedge clk);
        #1;
        rsp_rdy = '0;
        @(negedge clk);
        chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rsp_base;
        int others [NREQ];
        logic found;
        logic [PW-1:0] p1;

        vecs[0] = '{0, 12'hFFF, 12'h001, 24'h000FFE};
        vecs[1] = '{1, 12'h123, 12'h010, 24'h001231};
        vecs[2] = '{2, 12'hFFF, 12'hFFF, 24'hFFE000};
        vecs[3] = '{0, 12'h000, 12'h000, 24'h000001};
        vecs[4] = '{2, 12'hABC, 12'h100, 24'h0ABC01};
        vecs[5] = '{3, 12'h800, 12'h002, 24'h001001};

        // ---------------- Reset with all requests asserted ----------------
        rst_n   = 1'b0;
        rsp_rdy = '1;
        req_vld = '1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = W'(32'h3A5 + 32'(i) * 32'h111);
            req_b[i*W +: W] = W'(32'h0F0 + 32'(i));
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_rdy", 64'(req_rdy), 64'd0);
        chk("reset_mul_vld", 64'(mul_vld), 64'd0);
        chk("reset_rsp_vld", 64'(rsp_vld), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_grant_id", 64'(grant_id), 64'd3);
        chk("reset_rsp_p", 64'(rsp_p), 64'd0);

        // ---------------- Continuous round robin ----------------
        glog.delete();
        rsp_base = n_rsp;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("first_grant_req0", 64'(req_rdy), 64'b0001);
        repeat (30) @(posedge clk);
        #1;
        req_vld = '0;
        drain_and_check("rr");
        chk("rr_enough_grants", 64'(glog.size() >= 12), 64'd1);
        if (glog.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("rr_first_order", 64'(glog[k].id), 64'(k));
                chk("rr_consecutive", 64'(glog[k].cyc - glog[0].cyc), 64'(k));
            end
        end
        for (int k = 4; k < glog.size(); k++) begin
            for (int m = k - 1; m >= 0; m--) begin
                if (glog[m].id == glog[k].id) begin
                    chk("rr_regrant_gap", 64'(glog[k].cyc - glog[m].cyc), 64'(LAT + 3));
                    break;
                end
            end
        end
        chk("rr_rsp_count", 64'(n_rsp - rsp_base), 64'(glog.size()));

        // ---------------- Single ops from table ----------------
        for (int k = 0; k < 6; k++) begin
            single_op(vecs[k].id, vecs[k].a, vecs[k].b, vecs[k].exp_p);
        end

        // ---------------- Pointer wrap (grant_id = 3 after last vector) ----------------
        @(posedge clk); #1;
        req_vld = 4'b1001;
        @(negedge clk);
        chk("wrap_grant_id_start", 64'(grant_id), 64'd3);
        chk("wrap_first_req0", 64'(req_rdy), 64'b0001);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wrap_then_req3", 64'(req_rdy), 64'b1000);
        chk("wrap_grant_id_0", 64'(grant_id), 64'd0);
        @(posedge clk); #1;
        req_vld = '0;
        @(negedge clk);
        chk("wrap_grant_id_3", 64'(grant_id), 64'd3);
        drain_and_check("wrap");

        // ---------------- Backpressure on requester 1 ----------------
        @(posedge clk); #1;
        req_vld = '1;
        rsp_rdy = 4'b1101;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (rsp_vld[1]) found = 1'b1;
        end
        chk("bp_rsp1_seen", 64'(found), 64'd1);
        p1 = rsp_p[PW +: PW];
        chk("bp_rsp1_value", 64'(p1), 64'(amul(req_a[W +: W], req_b[W +: W])));
        for (int i = 0; i < NREQ; i++) others[i] = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("bp_rsp1_held", 64'(rsp_vld[1]), 64'd1);
            chk("bp_rsp1_stable", 64'(rsp_p[PW +: PW]), 64'(p1));
            chk("bp_req1_not_granted", 64'(req_rdy[1]), 64'd0);
            for (int i = 0; i < NREQ; i++) if (req_rdy[i]) others[i]++;
        end
        chk("bp_req0_issued", 64'(others[0] > 0), 64'd1);
        chk("bp_req2_issued", 64'(others[2] > 0), 64'd1);
        chk("bp_req3_issued", 64'(others[3] > 0), 64'd1);
        @(posedge clk); #1;
        req_vld = 4'b0010;
        rsp_rdy = '1;
        @(negedge clk);
        chk("bp_same_cycle_no_grant", 64'(req_rdy), 64'd0);
        chk("bp_rsp1_still_valid", 64'(rsp_vld[1]), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_req1_regranted", 64'(req_rdy), 64'b0010);
        @(posedge clk); #1;
        req_vld = '0;
        drain_and_check("bp");

        // ---------------- Reset mid-flight ----------------
        @(posedge clk); #1;
        fixed_en = 1'b1;
        req_vld  = 4'b0100;
        req_a[2*W +: W] = 12'h321;
        req_b[2*W +: W] = 12'h045;
        @(negedge clk);
        chk("rmf_req_rdy", 64'(req_rdy), 64'b0100);
        @(posedge clk); #1;
        req_vld = '0;
        @(negedge clk);
        chk("rmf_mul_vld", 64'(mul_vld), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rmf_busy", 64'(busy), 64'd0);
        chk("rmf_grant_id", 64'(grant_id), 64'd3);
        for (int k = 0; k < 8; k++) begin
            chk("rmf_no_rsp", 64'(rsp_vld), 64'd0);
            @(negedge clk);
        end
        fixed_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ap_mult_share_arb.md
Name: ap_mult_share_arb

Overview:
- Shares one approximate unsigned Wallace multiplier (12x12, evolved approximate-compressor tree) among NREQ requesters.
- Arbitration is round-robin. Each requester may have at most one operation in flight or waiting.
- The block drives the multiplier operand inputs and tracks in-flight tags through the multiplier's fixed pipeline latency.
- Each product is steered into a per-requester result slot with a valid/ready handshake.
- The multiplier instance sits outside this block. The block treats the product as opaque and does not correct or check it.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 12, operand width; product width is 2*W
LAT, 2, multiplier latency in cycles from mul_vld/operands to mul_p (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_vld  in  NREQ  request valid, per requester
req_rdy  out  NREQ  request accepted; one-hot or zero
req_a  in  NREQ*W  operand A; requester i at bits [i*W +: W]
req_b  in  NREQ*W  operand B, same packing
mul_vld  out  1  operands valid to multiplier (registered)
mul_a  out  W  operand A to multiplier (registered)
mul_b  out  W  operand B to multiplier (registered)
mul_p  in  2*W  multiplier product; sampled LAT cycles after mul_vld
rsp_vld  out  NREQ  result valid, per requester
rsp_p  out  NREQ*2*W  result; requester i at bits [i*2W +: 2W]
rsp_rdy  in  NREQ  result accepted, per requester
busy  out  1  OR of all pend flags
grant_id  out  clog2(NREQ)  index of the last granted requester (registered)

Behaviour:
- Reset (async assert, sync deassert handled upstream) clears:
  - req_rdy, mul_vld, mul_a, mul_b, rsp_vld, rsp_p, busy;
  - all pend flags;
  - the tag pipeline.
  Reset also sets grant_id = NREQ-1, so requester 0 has first priority.
- Per-requester flag pend[i] (registered):
  - set on handshake req_vld[i] & req_rdy[i];
  - cleared on rsp_vld[i] & rsp_rdy[i].
- eligible[i] = req_vld[i] & ~pend[i].
- Arbitration (combinational):
  - search eligible starting at grant_id+1 mod NREQ, wrapping;
  - the first hit gets req_rdy; at most one grant per cycle.
  - req_rdy depends combinationally on req_vld; a requester must not make req_vld depend on req_rdy.
- Issue, for a handshake in cycle T:
  - at the edge ending T: mul_a/mul_b <= that requester's operands, mul_vld <= 1, grant_id <= i;
  - with no handshake: mul_vld <= 0 and mul_a/mul_b hold their values.
- Tag pipeline:
  - LAT-deep shift register of {valid, id}, loaded alongside mul_vld;
  - its output aligns with mul_p in cycle T+1+LAT.
- Capture:
  - when the tag output is valid, rsp_p slot id <= mul_p and rsp_vld[id] <= 1 at that edge;
  - rsp_vld[id] is high from cycle T+2+LAT, so handshake-to-result latency is LAT+2 cycles;
  - mul_p is ignored when the tag is invalid.
- Response:
  - rsp_vld[i] and rsp_p slot i hold stable until rsp_rdy[i] is sampled high;
  - rsp_vld[i] and pend[i] clear at that edge;
  - requester i is eligible from the next cycle.
- Slot-overwrite freedom is guaranteed by pend: a capture never targets an occupied slot.
- Throughput: up to one issue per cycle across distinct requesters. Per requester, one operation per LAT+3 cycles minimum (rsp_rdy held high).
- Simultaneous events:
  - rsp handshake and new request on the same requester in one cycle → no grant that cycle (pend still set);
  - captures for different ids in consecutive cycles are independent.
- Reset mid-operation:
  - in-flight tags are discarded;
  - mul_p values returned after reset never produce rsp_vld;
  - the arbitration pointer returns to its reset value.
- busy = |pend, registered.
- Arithmetic: none. Products pass through bit-exact; no truncation or sign handling.

Test Plan:
- Reset: hold rst_n=0 with req_vld=4'hF -> req_rdy=0, mul_vld=0, rsp_vld=0, busy=0, grant_id=3. After release, the first grant goes to requester 0.
- Single op, LAT=2:
  - stimulus: req0 a=12'hFFF, b=12'h001 at cycle T; model drives mul_p=24'h000FFE at T+3;
  - required: req_rdy[0]=1 at T; mul_vld=1 with a/b at T+1; rsp_vld[0]=1 at T+4 with rsp_p[0]=24'h000FFE (the mul_p value, not the exact product).
- All four requesters valid continuously, rsp_rdy=4'hF:
  - grants in order 0,1,2,3 on consecutive cycles;
  - each requester is re-granted exactly LAT+3 cycles after its previous grant;
  - no response is lost or duplicated.
- Backpressure: rsp_rdy[1]=0 for 10 cycles after rsp_vld[1] -> rsp_p[1] stable, requester 1 never re-granted, requesters 0/2/3 keep issuing. After rsp_rdy[1]=1, requester 1 is granted again the cycle after the handshake.
- Pointer wrap: grant_id=3, only req3 and req0 valid -> req0 granted next, then req3.
- Reset mid-flight: pulse rst_n low the cycle after mul_vld with model mul_p=24'hABCDEF -> no rsp_vld ever asserts for that operation; busy=0 after reset.
